// File: rtl/word2byte.sv
// word2byte: word-to-byte serializer with a double-buffered input.
// An active shift register feeds the byte port while a pending register
// holds the next word, so consecutive words stream with no idle cycles.
// Optional macro WORD2BYTE_LAST_EN adds the byte_last output.
//
// state | meaning
// IDLE  | active register empty, nothing presented on the byte port
// SEND  | active register valid, bytes being presented
module word2byte #(
    parameter int BPW       = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_rdy,
    input  logic [BPW*8-1:0] word_in,
    output logic             in_akn,
    input  logic             out_akn,
    output logic             out_rdy,
    output logic [7:0]       byte_out,
`ifdef WORD2BYTE_LAST_EN
    output logic             byte_last,
`endif
    output logic             busy
);

    localparam int W  = BPW * 8;
    localparam int CW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST = CW'(BPW - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   act_q, act_d;
    logic [W-1:0]   pend_q, pend_d;
    logic           pend_v_q, pend_v_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           out_rdy_d, in_akn_d, busy_d;
    logic [7:0]     byte_out_d;
    logic           in_xfer, out_xfer, finish, present;
`ifdef WORD2BYTE_LAST_EN
    logic           last_d;
`endif

    // State, storage and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            act_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
            out_rdy  <= 1'b0;
            byte_out <= 8'h00;
            in_akn   <= 1'b0;
            busy     <= 1'b0;
`ifdef WORD2BYTE_LAST_EN
            byte_last <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            act_q    <= act_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            cnt_q    <= cnt_d;
            out_rdy  <= out_rdy_d;
            byte_out <= byte_out_d;
            in_akn   <= in_akn_d;
            busy     <= busy_d;
`ifdef WORD2BYTE_LAST_EN
            byte_last <= last_d;
`endif
        end
    end

    // Next-state logic: load, shift, pending hand-off and output values.
    always_comb begin
        state_d   = state_q;
        act_d     = act_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        cnt_d     = cnt_q;
        out_rdy_d = out_rdy;
        present   = 1'b0;
        in_xfer   = in_rdy && in_akn;
        out_xfer  = out_rdy && out_akn;
        finish    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    act_d     = word_in;
                    cnt_d     = '0;
                    state_d   = SEND;
                    out_rdy_d = 1'b1;
                    present   = 1'b1;
                end
            end
            SEND: begin
                finish = out_xfer && (cnt_q == LAST);
                if (out_xfer) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (pend_v_q) begin
                            act_d    = pend_q;
                            pend_v_d = 1'b0;
                            present  = 1'b1;
                        end else if (in_xfer) begin
                            // Bypass: the finishing word frees ACT on this edge.
                            act_d   = word_in;
                            present = 1'b1;
                        end else begin
                            state_d   = IDLE;
                            out_rdy_d = 1'b0;
                        end
                    end else begin
                        act_d   = (MSB_FIRST != 0) ? (act_q << 8) : (act_q >> 8);
                        cnt_d   = cnt_q + 1'b1;
                        present = 1'b1;
                    end
                end
                if (in_xfer && !(finish && !pend_v_q)) begin
                    pend_d   = word_in;
                    pend_v_d = 1'b1;
                end
            end
        endcase

        // byte_out keeps its last value when the block drains to IDLE.
        if (present)
            byte_out_d = (MSB_FIRST != 0) ? act_d[W-1 -: 8] : act_d[7:0];
        else
            byte_out_d = byte_out;

        in_akn_d = !pend_v_d;
        busy_d   = (state_d == SEND) || pend_v_d;
`ifdef WORD2BYTE_LAST_EN
        last_d   = out_rdy_d && (cnt_d == LAST);
`endif
    end

endmodule
